// File: rtl/systolic_feed_ctrl.sv
// Feed sequencer: loads the transpose FIFOs one row per memory read, then shifts them out as a diagonal wavefront.
// Optional feature: define FEED_CYCLE_CNT_EN to add the 16-bit cycle_cnt operation-length counter.
module systolic_feed_ctrl #(
    parameter int unsigned NUM_FIFOS = 8,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned PIPE_LAT  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_W-1:0]    base_addr,
    output logic                 mem_req,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic                 mem_rvalid,
    output logic [NUM_FIFOS-1:0] fifo_wren,
    output logic [NUM_FIFOS-1:0] fifo_en,
    output logic                 mac_en,
    output logic                 busy,
    output logic                 done
`ifdef FEED_CYCLE_CNT_EN
    ,
    output logic [15:0]          cycle_cnt
`endif
);

    localparam int unsigned ROW_LAST   = NUM_FIFOS - 1;
    localparam int unsigned T_LAST     = DEPTH + NUM_FIFOS - 2;
    localparam int unsigned FLUSH_LAST = (PIPE_LAT > 0) ? PIPE_LAT - 1 : 0;
    localparam int unsigned ROW_W      = (ROW_LAST > 0) ? $clog2(ROW_LAST + 1) : 1;
    localparam int unsigned T_W        = (T_LAST > 0) ? $clog2(T_LAST + 1) : 1;
    localparam int unsigned FLUSH_W    = (FLUSH_LAST > 0) ? $clog2(FLUSH_LAST + 1) : 1;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, FEED, FLUSH, DONE} state_t;

    state_t               state;
    logic [ROW_W-1:0]     row;
    logic [T_W-1:0]       t_cnt;
    logic [FLUSH_W-1:0]   flush_cnt;
    logic [ADDR_W-1:0]    base_q;
    logic                 mem_req_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [NUM_FIFOS-1:0] fifo_en_q;
    logic                 mac_en_q;
    logic                 busy_q;
    logic                 done_q;

    // FIFO k shifts during feed steps k .. k+DEPTH-1, giving the diagonal skew.
    function automatic logic [NUM_FIFOS-1:0] feed_mask(input logic [T_W-1:0] t);
        logic [NUM_FIFOS-1:0] m;
        m = '0;
        for (int k = 0; k < int'(NUM_FIFOS); k++) begin
            m[k] = (int'(t) >= k) && (int'(t) < k + int'(DEPTH));
        end
        return m;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            row        <= '0;
            t_cnt      <= '0;
            flush_cnt  <= '0;
            base_q     <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            fifo_en_q  <= '0;
            mac_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            fifo_en_q  <= '0;
            mac_en_q   <= 1'b0;
            done_q     <= 1'b0;
            if (abort) begin
                state  <= IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            base_q     <= base_addr;
                            row        <= '0;
                            state      <= REQ;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= base_addr;
                            busy_q     <= 1'b1;
                        end
                    end
                    REQ: state <= WAIT;
                    WAIT: begin
                        if (mem_rvalid) begin
                            if (row == ROW_W'(ROW_LAST)) begin
                                state     <= FEED;
                                t_cnt     <= '0;
                                fifo_en_q <= feed_mask(T_W'(0));
                                mac_en_q  <= 1'b1;
                            end else begin
                                row        <= row + ROW_W'(1);
                                state      <= REQ;
                                mem_req_q  <= 1'b1;
                                mem_addr_q <= base_q + ADDR_W'(row) + ADDR_W'(1);
                            end
                        end
                    end
                    FEED: begin
                        if (t_cnt == T_W'(T_LAST)) begin
                            if (PIPE_LAT > 0) begin
                                state     <= FLUSH;
                                flush_cnt <= '0;
                                mac_en_q  <= 1'b1;
                            end else begin
                                state  <= DONE;
                                done_q <= 1'b1;
                            end
                        end else begin
                            t_cnt     <= t_cnt + T_W'(1);
                            fifo_en_q <= feed_mask(t_cnt + T_W'(1));
                            mac_en_q  <= 1'b1;
                        end
                    end
                    FLUSH: begin
                        if (flush_cnt == FLUSH_W'(FLUSH_LAST)) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            flush_cnt <= flush_cnt + FLUSH_W'(1);
                            mac_en_q  <= 1'b1;
                        end
                    end
                    DONE: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Abort blanks every output in the cycle it is seen, ahead of the return to IDLE.
    assign mem_req   = mem_req_q & ~abort;
    assign mem_addr  = abort ? '0 : mem_addr_q;
    assign fifo_en   = abort ? '0 : fifo_en_q;
    assign mac_en    = mac_en_q & ~abort;
    assign busy      = busy_q & ~abort;
    assign done      = done_q & ~abort;
    assign fifo_wren = (state == WAIT && mem_rvalid && !abort) ? (NUM_FIFOS'(1) << row) : '0;

`ifdef FEED_CYCLE_CNT_EN
    // Counts every non-IDLE cycle of an operation; cleared only by an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
        end else if (state == IDLE) begin
            if (start && !abort) begin
                cycle_cnt <= '0;
            end
        end else if (cycle_cnt != 16'hFFFF) begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed bench for systolic_feed_ctrl: load/feed/flush timing, address wrap, abort and mid-operation reset.
// Build with FEED_CYCLE_CNT_EN defined to also cover the cycle_cnt output.
`timescale 1ns/1ps
module tb_systolic_feed_ctrl;

    localparam int unsigned NF = 8;
    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          force_rv = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_rvalid;
    logic [NF-1:0] fifo_wren;
    logic [NF-1:0] fifo_en;
    logic          mac_en;
    logic          busy;
    logic          done;
`ifdef FEED_CYCLE_CNT_EN
    logic [15:0]   cycle_cnt;
`endif

    logic [7:0]    pipe = '0;
    int            lat = 1;
    int            checks = 0;
    int            failures = 0;
    logic [AW-1:0] addr_log [NF];

    systolic_feed_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .fifo_wren  (fifo_wren),
        .fifo_en    (fifo_en),
        .mac_en     (mac_en),
        .busy       (busy),
        .done       (done)
`ifdef FEED_CYCLE_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory responder: rvalid follows each mem_req by lat cycles.
    always @(posedge clk) pipe <= {pipe[6:0], mem_req};
    assign mem_rvalid = pipe[3'(lat - 1)] | force_rv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {4'b0, busy, done, mac_en, mem_req, mem_addr, fifo_wren, fifo_en};
    endfunction

    // Expected outputs at cycle c of an operation started at cycle 0, for memory latency l.
    function automatic logic [31:0] exp_vec(input int c, input logic [7:0] b, input int l);
        int p, f, d, t;
        logic bsy, dn, mac, req;
        logic [7:0] ad, wr, en;
        p = l + 1;
        f = 1 + p * 8;
        d = f + 15 + 2;
        bsy = (c >= 1) && (c <= d);
        dn  = (c == d);
        req = 1'b0; ad = '0; wr = '0; en = '0; mac = 1'b0;
        if (c >= 1 && c < f) begin
            if ((c - 1) % p == 0) begin
                req = 1'b1;
                ad  = b + 8'((c - 1) / p);
            end
            if ((c - 1) % p == l) wr = 8'(1) << ((c - 1) / p);
        end
        if (c >= f && c < f + 15) begin
            t = c - f;
            mac = 1'b1;
            for (int k = 0; k < 8; k++) en[k] = (t >= k) && (t < k + 8);
        end
        if (c >= f + 15 && c < d) mac = 1'b1;
        return {4'b0, bsy, dn, mac, req, ad, wr, en};
    endfunction

    task automatic run_op(input logic [7:0] b, input int l, input int abort_at, input int rst_at);
        int d, f;
        logic [7:0] tbl;
        f = 1 + (l + 1) * 8;
        d = f + 17;
        lat = l;
        for (int c = 0; c <= d + 1; c++) begin
            @(negedge clk);
            start     = (c == 0) || (c == 5);
            base_addr = (c == 0) ? b : ~b;
            abort     = (c == abort_at);
            if (c == rst_at) rst_n = 1'b0;
            #1;
            if (c == abort_at || c == rst_at) begin
                check($sformatf("kill_b%0h_c%0d", b, c), obs(), 32'h0);
                break;
            end
            check($sformatf("b%0h_c%0d", b, c), obs(), exp_vec(c, b, l));
            if (mem_req && c >= 1 && c < f) addr_log[(c - 1) / (l + 1)] = mem_addr;
            if (l == 1 && c >= f && c < f + 15) begin
                tbl = 8'h00;
                case (c - f)
                    0:  tbl = 8'h01;
                    3:  tbl = 8'h0F;
                    7:  tbl = 8'hFF;
                    10: tbl = 8'hF8;
                    14: tbl = 8'h80;
                    default: tbl = 8'h00;
                endcase
                if (tbl != 8'h00) check($sformatf("skew_t%0d", c - f), 32'(fifo_en), 32'(tbl));
                if (c - f == 7) check("popcount_t7", 32'($countones(fifo_en)), 32'd8);
            end
`ifdef FEED_CYCLE_CNT_EN
            if (c == 1) check("cycle_cnt_cleared", 32'(cycle_cnt), 32'd0);
            if (c == d + 1) check("cycle_cnt_end", 32'(cycle_cnt), 32'(d));
`endif
            if (c == d + 1 && l == 3) begin
                check("wrap_row1", 32'(addr_log[1]), 32'h00FF);
                check("wrap_row2", 32'(addr_log[2]), 32'h0000);
                check("wrap_row7", 32'(addr_log[7]), 32'h0005);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", obs(), 32'h0);
`ifdef FEED_CYCLE_CNT_EN
        check("reset_cycle_cnt", 32'(cycle_cnt), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h10, 1, -1, -1);
        repeat (3) @(negedge clk);
        #1;
        check("idle_after_done", obs(), 32'h0);
`ifdef FEED_CYCLE_CNT_EN
        check("cycle_cnt_hold", 32'(cycle_cnt), 32'd34);
`endif

        run_op(8'hFE, 3, -1, -1);

        run_op(8'h20, 1, 22, -1);
        run_op(8'h40, 1, -1, -1);

        run_op(8'h30, 1, -1, 10);
        @(negedge clk);
        #1;
        check("reset_hold", obs(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        force_rv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("idle_rvalid_%0d", i), obs(), 32'h0);
        end
        force_rv = 1'b0;
        run_op(8'h50, 1, -1, -1);

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        #1;
        check("start_abort_same", obs(), 32'h0);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1;
        check("start_abort_idle", obs(), 32'h0);
        @(negedge clk);
        #1;
        check("start_abort_idle2", obs(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
